// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port unified memory.
// The instruction-fetch (I) port and the data load/store (D) port share the memory.
// One access is in flight at a time. A watchdog aborts any access that runs for
// TIMEOUT cycles without mem_ready and returns it with rsp_err set.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, requests that
// collide are granted alternately. When it is undefined, D always beats I.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16   // legal range 2..255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;     // 1 = D port, 0 = I port
  logic [7:0]        cnt_q, cnt_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_d;               // winner of the IDLE-cycle arbitration
  logic [DATA_W-1:0] rsp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;                    // last granted owner, 1 = D

  // On a collision, the requester that was not granted last time wins.
  always_comb begin
    pick_d = dm_req;
    if (dm_req && if_req) pick_d = ~last_q;
  end

  // Remember the owner of every grant.
  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && (dm_req || if_req)) last_d = pick_d;
  end

  // Last-owner register; resets to the I port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`else
  // Fixed priority: the data access belongs to the instruction in flight.
  always_comb pick_d = dm_req;
`endif

  // Stores return zero data; a load returns the word the memory presents.
  always_comb rsp_data = mem_we_q ? '0 : mem_rdata;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    err_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (dm_req || if_req) begin
          state_d     = StAccess;
          owner_d     = pick_d;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_d & dm_we;
          mem_addr_d  = pick_d ? dm_addr : if_addr;
          mem_wdata_d = pick_d ? dm_wdata : '0;
          busy_d      = 1'b1;
          dm_gnt_d    = pick_d;
          if_gnt_d    = ~pick_d;
        end
      end
      StAccess: begin
        // mem_ready wins over the watchdog when both happen on the same edge.
        if (mem_ready || cnt_q == CntLast) begin
          state_d     = StResp;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          err_d       = ~mem_ready;
          dm_rvalid_d = owner_q;
          if_rvalid_d = ~owner_q;
          if (mem_ready) begin
            if (owner_q) dm_rdata_d = rsp_data;
            else         if_rdata_d = rsp_data;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        mem_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset drops any in-flight access silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign rsp_err   = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// The stimulus pushes the expected grants and responses into queues. A monitor pops
// and compares those entries whenever the DUT pulses gnt or rvalid.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_wdata, mem_rdata, if_rdata, dm_rdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, rsp_err;
  logic          mem_en, mem_we, mem_ready, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Memory contents: a fixed instruction at 0x40, an address-derived pattern elsewhere.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction
  assign mem_rdata = memfn(mem_addr);

  int n_chk = 0;
  int n_pass = 0;
  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endfunction

  typedef struct packed {logic is_d; logic [31:0] data; logic err;} rsp_t;
  rsp_t rsp_q[$];
  logic gnt_q[$];
  int   n_rvalid = 0;

  // Memory model: raise mem_ready during the mem_lat-th access cycle (0 = never).
  int mem_lat = 0;
  int acc_n = 0;
  int en_total = 0;
  int we_total = 0;
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        acc_n = acc_n + 1;
        en_total = en_total + 1;
        if (mem_we) we_total = we_total + 1;
        mem_ready = (mem_lat != 0) && (acc_n == mem_lat);
      end else begin
        acc_n = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: compare each grant and response pulse against the scoreboard.
  initial begin
    logic ed;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", {62'b0, if_gnt, dm_gnt}, 64'd0);
        else begin
          ed = gnt_q.pop_front();
          check("gnt_port", {62'b0, if_gnt, dm_gnt}, ed ? 64'd1 : 64'd2);
        end
      end
      if (if_rvalid || dm_rvalid) begin
        n_rvalid++;
        if (rsp_q.size() == 0) check("rvalid_unexpected", {62'b0, if_rvalid, dm_rvalid}, 64'd0);
        else begin
          r = rsp_q.pop_front();
          check("rsp_port", {62'b0, if_rvalid, dm_rvalid}, r.is_d ? 64'd1 : 64'd2);
          check("rsp_rdata", r.is_d ? 64'(dm_rdata) : 64'(if_rdata), 64'(r.data));
          check("rsp_err", 64'(rsp_err), 64'(r.err));
          check("rsp_other_zero", r.is_d ? 64'({if_rvalid, if_rdata}) : 64'({dm_rvalid, dm_rdata}),
                64'd0);
        end
      end
    end
  end

  logic exp_last = 1'b0;  // model of the last granted owner, 1 = D

  function automatic logic winner();
`ifdef ARB_ROUND_ROBIN_EN
    return ~exp_last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, output int k);
    k = 0;
    while (busy && k < 300) begin
      cyc(1);
      k++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // One request from a single port; lat = ready cycle, 0 = never ready (watchdog).
  task automatic single(input string name, input logic is_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    int k, acc, en0, we0;
    logic err;
    rsp_t r;
    err = (lat == 0) || (lat > int'(TO));
    acc = err ? int'(TO) : lat;
    mem_lat = lat;
    en0 = en_total;
    we0 = we_total;
    if (is_d) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    gnt_q.push_back(is_d);
    r.is_d = is_d;
    r.err  = err;
    r.data = (err || (is_d && we)) ? 32'd0 : memfn(addr);
    rsp_q.push_back(r);
    exp_last = is_d;
    cyc(1);
    check({name, "_gnt"}, 64'(is_d ? dm_gnt : if_gnt), 64'd1);
    check({name, "_addr"}, 64'(mem_addr), 64'(addr));
    check({name, "_we"}, 64'(mem_we), 64'(is_d & we));
    check({name, "_wdata"}, 64'(mem_wdata), is_d ? 64'(wdata) : 64'd0);
    dm_req = 1'b0;
    if_req = 1'b0;
    wait_idle(name, k);
    check({name, "_idle_cycle"}, 64'(k), 64'(acc + 1));
    check({name, "_en_cycles"}, 64'(en_total - en0), 64'(acc));
    check({name, "_we_cycles"}, 64'(we_total - we0), (is_d && we) ? 64'(acc) : 64'd0);
  endtask

  // Both ports request in the same IDLE cycle; second grant lands three cycles later.
  task automatic collide(input string name);
    logic first;
    int k;
    rsp_t r;
    first = winner();
    mem_lat = 1;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    gnt_q.push_back(first);
    gnt_q.push_back(~first);
    r.err = 1'b0;
    r.is_d = first;  r.data = memfn(first ? 32'h200 : 32'h80);
    rsp_q.push_back(r);
    r.is_d = ~first; r.data = memfn(first ? 32'h80 : 32'h200);
    rsp_q.push_back(r);
    cyc(1);
    check({name, "_first_gnt"}, 64'(first ? dm_gnt : if_gnt), 64'd1);
    if (first) dm_req = 1'b0;
    else       if_req = 1'b0;
    cyc(3);
    check({name, "_second_gnt"}, 64'(first ? if_gnt : dm_gnt), 64'd1);
    dm_req = 1'b0;
    if_req = 1'b0;
    exp_last = ~first;
    wait_idle(name, k);
  endtask

  initial begin
    int nr;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    cyc(2);
    check("reset_outputs", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                 rsp_err, mem_en, mem_we, mem_addr, mem_wdata, busy}), 64'd0);
    reset = 1'b1;
    cyc(2);

    single("fetch", 1'b0, 1'b0, 32'h40, 32'h0, 1);
    single("store", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3);
    single("load", 1'b1, 1'b0, 32'h124, 32'h0, 2);
    collide("coll1");
    collide("coll2");
    single("timeout", 1'b0, 1'b0, 32'h300, 32'h0, 0);
    single("after_to", 1'b0, 1'b0, 32'h44, 32'h0, 2);
    single("ready_at_to", 1'b1, 1'b0, 32'h404, 32'h0, int'(TO));

    // Reset in the middle of a never-completing access.
    mem_lat = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    gnt_q.push_back(1'b1);
    cyc(1);
    check("rstmid_gnt", 64'(dm_gnt), 64'd1);
    dm_req = 1'b0;
    cyc(2);
    check("rstmid_en_before", 64'(mem_en), 64'd1);
    nr = n_rvalid;
    #2 reset = 1'b0;
    #1;
    check("rstmid_async_outputs", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                        rsp_err, mem_en, mem_we, mem_addr, mem_wdata, busy}),
          64'd0);
    exp_last = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(5);
    check("rstmid_no_rvalid", 64'(n_rvalid), 64'(nr));
    single("post_rst", 1'b0, 1'b0, 32'h48, 32'h0, 1);

    cyc(3);
    check("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
